cache_miss_ctrl: RTL and testbench
==================================

// Module: cache_miss_ctrl
// PURPOSE
//   Miss sequencer between the dual-port 2-way write-back data cache and the single-port main memory.
//   - Captures read/write misses from issue port 0 and port 1.
//   - Serialises them onto one memory channel: dirty-victim writeback first, then line refill.
//   - Pulses the cache fill strobes: write-allocate fill (we2 / we2_2) and read-miss fill (we3 / we3_2).
//   - Holds the pipeline stall while any miss is outstanding.
// PARAMETERS
//   TAG_W    20    tag width (addr[31:12]); index is addr[11:2]
//   LINE_W   128   cache line width (4 x 32-bit words)
//   TIMEOUT  255   watchdog limit in cycles; used only when MISS_CTRL_TIMEOUT_EN is defined
// PORTS
//   clk             in   1       system clock, rising edge
//   rst_n           in   1       asynchronous, active-low reset
//   miss_rd0/1      in   1       read miss on port 0/1, valid in the sampling cycle
//   miss_wr0/1      in   1       write miss on port 0/1
//   addr0/1         in   32      word address of the missing access
//   dirty0/1        in   1       victim way is dirty
//   victim_tag0/1   in   TAG_W   tag of the victim line
//   victim_line0/1  in   LINE_W  data of the victim line
//   mem_req         out  1       memory request, held until ack
//   mem_we          out  1       1 = line write (writeback), 0 = line read (refill)
//   mem_addr        out  32      line-aligned address, bits [1:0] = 0
//   mem_wdata       out  LINE_W  writeback data
//   mem_rdata       in   LINE_W  refill data, valid when mem_ack = 1
//   mem_ack         in   1       one-cycle completion strobe
//   refill_line     out  LINE_W  refill data to cache (readdatamemory / readmisswritetocache)
//   fill_wr0/1      out  1       1-cycle write-allocate fill strobe (we2 / we2_2)
//   fill_rd0/1      out  1       1-cycle read-miss fill strobe (we3 / we3_2)
//   stall           out  1       freeze fetch/issue
//   busy            out  1       FSM not in IDLE
// BEHAVIOUR
//   Reset (async, rst_n = 0):
//     - All outputs 0; refill_line = 0; both pending slots cleared; FSM = IDLE.
//     - An in-flight memory transaction is abandoned. Memory must tolerate a dropped mem_req.
//   Capture (every rising edge):
//     - A free slot p latches {kind, addr, dirty, victim_tag, victim_line} when miss_rdp | miss_wrp.
//     - miss_rd and miss_wr high together on the same port: the read wins and the write is dropped.
//     - A miss on a port whose slot is already full is ignored (the pipeline is stalled).
//   stall = miss_rd0 | miss_rd1 | miss_wr0 | miss_wr1 | pend0 | pend1 | busy.
//     - Combinational, so it rises in the same cycle as the miss.
//   Arbitration:
//     - Port 0 is served before port 1 (program order), including when both miss in the same cycle.
//     - Non-preemptive: a started sequence runs to completion.
//   FSM: IDLE -> (WB_REQ if dirty) -> RF_REQ -> FILL -> IDLE, or directly to the next pending slot.
//     IDLE:    a slot is pending -> select it, then go to WB_REQ if dirty, else RF_REQ.
//     WB_REQ:  mem_req = 1, mem_we = 1, mem_addr = {victim_tag, addr[11:2], 2'b00}, mem_wdata = victim_line.
//              mem_ack -> RF_REQ.
//     RF_REQ:  mem_req = 1, mem_we = 0, mem_addr = {addr[31:2], 2'b00}.
//              mem_ack -> capture mem_rdata into refill_line, go to FILL.
//     FILL:    exactly one of fill_rd/fill_wr for the selected port is high for 1 cycle.
//              refill_line is held stable through FILL and the following cycle.
//              The slot is cleared; go to IDLE.
//   Handshake:
//     - mem_req, mem_we, mem_addr and mem_wdata are constant from request assertion through the ack cycle.
//     - mem_req drops in the cycle after mem_ack.
//     - mem_ack outside WB_REQ/RF_REQ is ignored.
//   Latency (miss sampled at edge 0, memory acks in its L-th request cycle):
//     - Clean miss: fill strobe in cycle L+2; stall low from cycle L+3 if nothing else is pending.
//     - Dirty miss: add the writeback time. The refill request starts the cycle after the writeback ack.
//   Both ports missing:
//     - Port 1 starts in the cycle after port 0's FILL.
//     - stall stays high continuously between the two sequences.
// CONFIGURATION
//   MISS_CTRL_TIMEOUT_EN defined:
//     - An 8-bit counter runs while mem_req = 1.
//     - If it reaches TIMEOUT without mem_ack: mem_req drops, the slot is cleared, no fill strobe is issued, FSM = IDLE.
//     - Adds output err (1 bit), sticky until reset.
//   MISS_CTRL_TIMEOUT_EN undefined:
//     - No counter, no err port; the controller waits for mem_ack indefinitely.
// TESTING
//   1 Clean read miss port0, addr0 = 0x0000_1234, ack latency 20 -> one refill at mem_addr 0x0000_1234;
//     fill_rd0 single pulse; refill_line = mem_rdata; stall low 23 cycles after the miss.
//   2 Dirty write miss port1, addr1 = 0x0ABC_D008, victim_tag1 = 0x12345 -> writeback at 0x1234_5008
//     with victim_line1, then refill at 0x0ABC_D008; fill_wr1 pulses once.
//   3 miss_rd0 and miss_wr1 in the same cycle -> port0 fully served (fill_rd0) before port1's mem_req;
//     stall never drops between the two.
//   4 rst_n low mid-RF_REQ -> mem_req, stall, busy and fill strobes 0 immediately;
//     after release with no misses, no strobe ever fires.
//   5 mem_ack held 0, TIMEOUT = 255 (with MISS_CTRL_TIMEOUT_EN) -> err = 1 after 255 request cycles; busy = 0.
//   6 miss_rd0 and miss_wr0 high together -> only fill_rd0 pulses; no fill_wr0.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer: serialises port 0/1 cache misses into writeback + refill memory transactions.
// Optional request watchdog with sticky err output when MISS_CTRL_TIMEOUT_EN is defined.
module cache_miss_ctrl #(
  parameter int unsigned TAG_W  = 20,
  parameter int unsigned LINE_W = 128
`ifdef MISS_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_rd0,
  input  logic              miss_rd1,
  input  logic              miss_wr0,
  input  logic              miss_wr1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic              dirty0,
  input  logic              dirty1,
  input  logic [TAG_W-1:0]  victim_tag0,
  input  logic [TAG_W-1:0]  victim_tag1,
  input  logic [LINE_W-1:0] victim_line0,
  input  logic [LINE_W-1:0] victim_line1,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [LINE_W-1:0] refill_line,
  output logic              fill_wr0,
  output logic              fill_wr1,
  output logic              fill_rd0,
  output logic              fill_rd1,
`ifdef MISS_CTRL_TIMEOUT_EN
  output logic              err,
`endif
  output logic              stall,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WB_REQ, RF_REQ, FILL} state_t;
  state_t state, state_next;

  logic [1:0]        miss_rd, miss_wr, dirty_in;
  logic [1:0]        pend, is_rd, dirty_q, clr, fill_rd, fill_wr;
  logic [31:0]       addr_in   [2];
  logic [TAG_W-1:0]  tag_in    [2];
  logic [LINE_W-1:0] line_in   [2];
  logic [29:0]       line_addr [2];
  logic [TAG_W-1:0]  tag_q     [2];
  logic [LINE_W-1:0] vline_q   [2];
  logic              sel, sel_next, tmo;
  logic              unused_addr_lsbs;

  assign miss_rd    = {miss_rd1, miss_rd0};
  assign miss_wr    = {miss_wr1, miss_wr0};
  assign dirty_in   = {dirty1, dirty0};
  assign addr_in[0] = addr0;
  assign addr_in[1] = addr1;
  assign tag_in[0]  = victim_tag0;
  assign tag_in[1]  = victim_tag1;
  assign line_in[0] = victim_line0;
  assign line_in[1] = victim_line1;
  assign unused_addr_lsbs = ^{addr0[1:0], addr1[1:0]};

  // Pending slots: a full slot ignores further misses until its sequence clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      is_rd   <= '0;
      dirty_q <= '0;
      for (int unsigned p = 0; p < 2; p++) begin
        line_addr[p] <= '0;
        tag_q[p]     <= '0;
        vline_q[p]   <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (clr[p]) begin
          pend[p] <= 1'b0;
        end else if (!pend[p] && (miss_rd[p] || miss_wr[p])) begin
          pend[p]      <= 1'b1;
          is_rd[p]     <= miss_rd[p];
          dirty_q[p]   <= dirty_in[p];
          line_addr[p] <= addr_in[p][31:2];
          tag_q[p]     <= tag_in[p];
          vline_q[p]   <= line_in[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= 1'b0;
      refill_line <= '0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
      if (state == RF_REQ && mem_ack) refill_line <= mem_rdata;
    end
  end

  always_comb begin
    state_next = state;
    sel_next   = sel;
    clr        = '0;
    fill_rd    = '0;
    fill_wr    = '0;
    case (state)
      IDLE: begin
        if (pend[0]) begin
          sel_next   = 1'b0;
          state_next = dirty_q[0] ? WB_REQ : RF_REQ;
        end else if (pend[1]) begin
          sel_next   = 1'b1;
          state_next = dirty_q[1] ? WB_REQ : RF_REQ;
        end
      end
      WB_REQ: begin
        if (tmo) begin
          clr[sel]   = 1'b1;
          state_next = IDLE;
        end else if (mem_ack) begin
          state_next = RF_REQ;
        end
      end
      RF_REQ: begin
        if (tmo) begin
          clr[sel]   = 1'b1;
          state_next = IDLE;
        end else if (mem_ack) begin
          state_next = FILL;
        end
      end
      FILL: begin
        clr[sel] = 1'b1;
        if (is_rd[sel]) fill_rd[sel] = 1'b1;
        else            fill_wr[sel] = 1'b1;
        // Chain straight into the other slot so stall never dips between sequences
        if (pend[~sel]) begin
          sel_next   = ~sel;
          state_next = dirty_q[~sel] ? WB_REQ : RF_REQ;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_req = (state == WB_REQ) || (state == RF_REQ);
  assign mem_we  = (state == WB_REQ);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == WB_REQ) begin
      mem_addr  = {tag_q[sel], line_addr[sel][9:0], 2'b00};
      mem_wdata = vline_q[sel];
    end else if (state == RF_REQ) begin
      mem_addr  = {line_addr[sel], 2'b00};
    end
  end

  assign fill_rd0 = fill_rd[0];
  assign fill_rd1 = fill_rd[1];
  assign fill_wr0 = fill_wr[0];
  assign fill_wr1 = fill_wr[1];
  assign busy     = (state != IDLE);
  assign stall    = (|miss_rd) || (|miss_wr) || (|pend) || busy;

`ifdef MISS_CTRL_TIMEOUT_EN
  logic [7:0] tcnt;

  // Fires in the TIMEOUT-th consecutive request cycle without an ack
  assign tmo = mem_req && !mem_ack && (tcnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      err <= err || tmo;
      if (!mem_req || mem_ack || tmo) tcnt <= '0;
      else                            tcnt <= tcnt + 8'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: directed and randomized misses against a
// timed transaction schedule (writeback, refill, fill) with a reactive memory model.
module tb_cache_miss_ctrl;
  localparam int unsigned TAG_W  = 20;
  localparam int unsigned LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              miss_rd0 = 1'b0, miss_rd1 = 1'b0, miss_wr0 = 1'b0, miss_wr1 = 1'b0;
  logic [31:0]       addr0 = '0, addr1 = '0;
  logic              dirty0 = 1'b0, dirty1 = 1'b0;
  logic [TAG_W-1:0]  victim_tag0 = '0, victim_tag1 = '0;
  logic [LINE_W-1:0] victim_line0 = '0, victim_line1 = '0;
  logic              mem_req, mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic [LINE_W-1:0] refill_line;
  logic              fill_wr0, fill_wr1, fill_rd0, fill_rd1;
  logic              stall, busy;
`ifdef MISS_CTRL_TIMEOUT_EN
  logic              err;
`endif
  logic [3:0]        fills;

  assign fills = {fill_wr1, fill_wr0, fill_rd1, fill_rd0};

  always #5 clk = ~clk;

  cache_miss_ctrl #(.TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_rd0(miss_rd0), .miss_rd1(miss_rd1), .miss_wr0(miss_wr0), .miss_wr1(miss_wr1),
    .addr0(addr0), .addr1(addr1), .dirty0(dirty0), .dirty1(dirty1),
    .victim_tag0(victim_tag0), .victim_tag1(victim_tag1),
    .victim_line0(victim_line0), .victim_line1(victim_line1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .refill_line(refill_line),
    .fill_wr0(fill_wr0), .fill_wr1(fill_wr1), .fill_rd0(fill_rd0), .fill_rd1(fill_rd1),
`ifdef MISS_CTRL_TIMEOUT_EN
    .err(err),
`endif
    .stall(stall), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  typedef enum int {OP_WB, OP_RF, OP_FILL} op_kind_t;
  typedef struct {
    op_kind_t     kind;
    logic [31:0]  addr;
    logic [127:0] data;
    int           lat;
    logic [3:0]   fill;
  } op_t;

  op_t          ops[$];
  logic [127:0] exp_refill = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_misses();
    miss_rd0 = 1'b0; miss_rd1 = 1'b0; miss_wr0 = 1'b0; miss_wr1 = 1'b0;
  endtask

  // Drives one port's miss and appends the transactions it must produce
  task automatic add_miss(input bit port, input bit rd, input bit wr, input logic [31:0] addr,
                          input bit dirty, input logic [19:0] tag, input logic [127:0] line,
                          input int lwb, input int lrf, input logic [127:0] rdata);
    op_t o;
    if (port) begin
      miss_rd1 = rd; miss_wr1 = wr; addr1 = addr; dirty1 = dirty;
      victim_tag1 = tag; victim_line1 = line;
    end else begin
      miss_rd0 = rd; miss_wr0 = wr; addr0 = addr; dirty0 = dirty;
      victim_tag0 = tag; victim_line0 = line;
    end
    if (rd || wr) begin
      if (dirty) begin
        o.kind = OP_WB; o.addr = {tag, addr[11:2], 2'b00}; o.data = line; o.lat = lwb; o.fill = '0;
        ops.push_back(o);
      end
      o.kind = OP_RF; o.addr = {addr[31:2], 2'b00}; o.data = rdata; o.lat = lrf; o.fill = '0;
      ops.push_back(o);
      o.kind = OP_FILL; o.addr = '0; o.data = '0; o.lat = 1;
      o.fill = rd ? (4'b0001 << port) : (4'b0100 << port);
      ops.push_back(o);
    end
  endtask

  // Cycle 0 = misses driven, cycle 1 = capture/select, then ops back to back
  task automatic run_seq(input bit spurious);
    int  idx;
    int  rc;
    op_t o;
    idx = 0;
    rc  = 0;
    #1;
    chk("miss_stall", stall, 1'b1);
    chk("miss_busy", busy, 1'b0);
    tick();
    clear_misses();
    mem_ack = spurious;
    mem_rdata = rand128();
    #1;
    chk("sel_stall", stall, 1'b1);
    chk("sel_req", mem_req, 1'b0);
    for (int g = 0; g < 300 && idx < ops.size(); g++) begin
      tick();
      mem_ack = 1'b0;
      mem_rdata = rand128();
      o = ops[idx];
      chk("stall_hold", stall, 1'b1);
      chk("busy_hold", busy, 1'b1);
      if (o.kind == OP_FILL) begin
        chk("fill_req", mem_req, 1'b0);
        chk("fill_vec", fills, o.fill);
        chk("fill_line", refill_line, exp_refill);
        idx++;
      end else begin
        chk("req", mem_req, 1'b1);
        chk("we", mem_we, (o.kind == OP_WB));
        chk("addr", mem_addr, o.addr);
        chk("no_fill", fills, 4'b0);
        if (o.kind == OP_WB) chk("wdata", mem_wdata, o.data);
        rc++;
        if (rc == o.lat) begin
          mem_ack = 1'b1;
          if (o.kind == OP_RF) begin
            mem_rdata  = o.data;
            exp_refill = o.data;
          end
          rc = 0;
          idx++;
        end
      end
    end
    chk("seq_done", idx, ops.size());
    tick();
    mem_ack = 1'b0;
    chk("end_stall", stall, 1'b0);
    chk("end_busy", busy, 1'b0);
    chk("end_req", mem_req, 1'b0);
    chk("end_fill", fills, 4'b0);
    chk("end_line_held", refill_line, exp_refill);
  endtask

  initial begin
    int unsigned m;
    int unsigned k;
    bit          bad;
    int          n;

    tick();
    tick();
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 128'h0);
    chk("rst_line", refill_line, 128'h0);
    chk("rst_fill", fills, 4'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_busy", busy, 1'b0);
`ifdef MISS_CTRL_TIMEOUT_EN
    chk("rst_err", err, 1'b0);
`endif
    rst_n = 1'b1;
    tick();

    // Clean read miss, ack latency 20
    ops.delete();
    add_miss(1'b0, 1'b1, 1'b0, 32'h0000_1234, 1'b0, 20'h0, rand128(), 1, 20, rand128());
    run_seq(1'b0);
    tick();

    // Dirty write miss on port 1
    ops.delete();
    add_miss(1'b1, 1'b0, 1'b1, 32'h0ABC_D008, 1'b1, 20'h12345, rand128(), 4, 5, rand128());
    run_seq(1'b0);

    // Both ports in the same cycle
    ops.delete();
    add_miss(1'b0, 1'b1, 1'b0, 32'h0000_4440, 1'b0, 20'h0, rand128(), 1, 3, rand128());
    add_miss(1'b1, 1'b0, 1'b1, 32'h8000_0F0C, 1'b1, 20'hABCDE, rand128(), 2, 2, rand128());
    run_seq(1'b1);

    // Read and write together on port 0: read wins
    ops.delete();
    add_miss(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 20'h0, rand128(), 1, 2, rand128());
    run_seq(1'b0);

    for (int it = 0; it < 24; it++) begin
      ops.delete();
      m = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        if (m[p]) begin
          k = $urandom_range(0, 2);
          add_miss(p[0], (k != 1), (k != 0), $urandom, $urandom_range(0, 1) == 1, 20'($urandom),
                   rand128(), int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), rand128());
        end
      end
      run_seq(it[0]);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Reset in the middle of a refill request
    ops.delete();
    add_miss(1'b0, 1'b1, 1'b0, 32'h0000_2000, 1'b0, 20'h0, rand128(), 1, 1, rand128());
    tick();
    clear_misses();
    tick();
    tick();
    tick();
    chk("pre_rst_req", mem_req, 1'b1);
    chk("pre_rst_we", mem_we, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_refill = '0;
    chk("async_rst_req", mem_req, 1'b0);
    chk("async_rst_stall", stall, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_fill", fills, 4'b0);
    chk("async_rst_line", refill_line, exp_refill);
    tick();
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      tick();
      if (fills != 4'b0 || mem_req || stall) bad = 1'b1;
    end
    chk("post_rst_quiet", bad, 1'b0);

`ifdef MISS_CTRL_TIMEOUT_EN
    ops.delete();
    add_miss(1'b0, 1'b1, 1'b0, 32'h0000_3000, 1'b0, 20'h0, rand128(), 1, 1, rand128());
    tick();
    clear_misses();
    n   = 0;
    bad = 1'b0;
    for (int g = 0; g < 400; g++) begin
      tick();
      if (fills != 4'b0) bad = 1'b1;
      if (mem_req) n++;
      else if (n > 0) break;
    end
    chk("tmo_cycles", n, 255);
    chk("tmo_err", err, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_stall", stall, 1'b0);
    chk("tmo_no_fill", bad, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
